// File: rtl/core_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : core_bus_arbiter
//  Description : Round-robin arbiter that time-multiplexes four processing
//                cores onto the shared bus/control path. It holds each grant
//                for a bounded time slice, retires cores as they raise endp,
//                and flags completion of the whole run.
//  Ports       : clk         - system clock, rising edge
//                rst         - synchronous active-high reset
//                start       - one-cycle run start pulse (ignored while busy)
//                core_en     - participating cores, sampled on accepted start
//                core_req    - per-core bus request (level)
//                core_endp   - per-core program finished (level)
//                select_core - registered mux select, 0 = none, 1..4 = core
//                grant       - registered one-hot decode of select_core
//                busy        - registered, high while a run is in progress
//                all_done    - registered, high once every enabled core ended
//  Revision    : 1.0 - initial release
// ============================================================================
module core_bus_arbiter #(
    parameter int SLICE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] core_en,
    input  logic [3:0] core_req,
    input  logic [3:0] core_endp,
    output logic [2:0] select_core,
    output logic [3:0] grant,
    output logic       busy,
    output logic       all_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        GRANT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] c_SLICE_LAST = 8'(SLICE - 1);
    localparam logic [2:0] c_PTR_RESET  = 3'd4;

    state_t     r_state,     w_state;
    logic [3:0] r_en_mask,   w_en_mask;
    logic [3:0] r_done_mask, w_done_mask;
    logic [2:0] r_ptr,       w_ptr;
    logic [7:0] r_cnt,       w_cnt;
    logic [2:0] r_sel,       w_sel;
    logic [3:0] r_grant,     w_grant;
    logic       r_busy,      w_busy;
    logic       r_all_done,  w_all_done;

    logic [3:0] w_done_upd;
    logic [3:0] w_elig;
    logic [3:0] w_cur_oh;
    logic       w_other;
    logic       w_slice_end;

    // One-hot decode of a core number (1..4); 0 decodes to no bits.
    function automatic logic [3:0] f_onehot(input logic [2:0] sel);
        logic [3:0] oh;
        case (sel)
            3'd1:    oh = 4'b0001;
            3'd2:    oh = 4'b0010;
            3'd3:    oh = 4'b0100;
            3'd4:    oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

    // First eligible core searching ptr+1, ptr+2, ... with wrap 4->1.
    // Scanning from the farthest offset down lets the nearest one win.
    function automatic logic [2:0] f_pick(input logic [2:0] ptr, input logic [3:0] elig);
        logic [2:0] win;
        logic [1:0] idx;
        win = 3'd0;
        for (int off = 4; off >= 1; off--) begin
            // ptr is 1-based; adding 3 is subtracting 1 modulo 4
            idx = ptr[1:0] + 2'(off) + 2'd3;
            if (elig[idx]) begin
                win = {1'b0, idx} + 3'd1;
            end
        end
        return win;
    endfunction

    always_comb begin
        w_state     = r_state;
        w_en_mask   = r_en_mask;
        w_done_mask = r_done_mask;
        w_ptr       = r_ptr;
        w_cnt       = r_cnt;
        w_sel       = r_sel;
        w_busy      = r_busy;
        w_all_done  = r_all_done;

        // Finished cores are retired in the same cycle their endp is seen,
        // so they can never win this cycle's arbitration.
        w_done_upd  = r_done_mask | (core_endp & r_en_mask);
        w_elig      = core_req & r_en_mask & ~w_done_upd;
        w_cur_oh    = f_onehot(r_sel);
        w_other     = |(w_elig & ~w_cur_oh);
        w_slice_end = (r_cnt == c_SLICE_LAST);

        case (r_state)
            IDLE, DONE: begin
                w_sel = 3'd0;
                if (start) begin
                    if (core_en != 4'b0000) begin
                        w_state     = ARB;
                        w_en_mask   = core_en;
                        w_done_mask = 4'b0000;
                        w_ptr       = c_PTR_RESET;
                        w_busy      = 1'b1;
                        w_all_done  = 1'b0;
                    end else begin
                        w_state     = DONE;
                        w_busy      = 1'b0;
                        w_all_done  = 1'b1;
                    end
                end
            end
            ARB: begin
                w_done_mask = w_done_upd;
                w_sel       = 3'd0;
                if (w_done_upd == r_en_mask) begin
                    w_state    = DONE;
                    w_busy     = 1'b0;
                    w_all_done = 1'b1;
                end else if (|w_elig) begin
                    w_state = GRANT;
                    w_sel   = f_pick(r_ptr, w_elig);
                    w_cnt   = 8'd0;
                end
            end
            GRANT: begin
                w_done_mask = w_done_upd;
                // endp, dropped request and preemption all release the bus;
                // endp takes priority simply by being part of the same release.
                if ((|(core_endp & w_cur_oh)) ||
                    !(|(core_req & w_cur_oh)) ||
                    (w_slice_end && w_other)) begin
                    w_state = ARB;
                    w_ptr   = r_sel;
                    w_sel   = 3'd0;
                end else if (w_slice_end) begin
                    w_cnt = 8'd0;
                end else begin
                    w_cnt = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state = IDLE;
                w_sel   = 3'd0;
            end
        endcase

        w_grant = f_onehot(w_sel);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_en_mask   <= 4'b0000;
            r_done_mask <= 4'b0000;
            r_ptr       <= c_PTR_RESET;
            r_cnt       <= 8'd0;
            r_sel       <= 3'd0;
            r_grant     <= 4'b0000;
            r_busy      <= 1'b0;
            r_all_done  <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_en_mask   <= w_en_mask;
            r_done_mask <= w_done_mask;
            r_ptr       <= w_ptr;
            r_cnt       <= w_cnt;
            r_sel       <= w_sel;
            r_grant     <= w_grant;
            r_busy      <= w_busy;
            r_all_done  <= w_all_done;
        end
    end

    assign select_core = r_sel;
    assign grant       = r_grant;
    assign busy        = r_busy;
    assign all_done    = r_all_done;

endmodule
`default_nettype wire
